// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands/control, detects load-use
// hazards, inserts bubbles on hazard/flush and keeps saturating perf counters.
module id_ex_reg #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_ALUOp,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [6:0]        id_ctrl,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_ALUOp,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [6:0]        ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Bit position of MemRead in {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump}
  localparam int unsigned MEMREAD_BIT = 5;

  logic do_bubble;
  logic do_hold;
  logic do_load;
  logic bubble_count;

  // Load-use: the load in EX writes a register the instruction in ID reads
  assign hazard_stall = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Per-cycle action selection; flush outranks stall, stall outranks hazard
  always_comb begin
    do_bubble    = 1'b0;
    do_hold      = 1'b0;
    do_load      = 1'b0;
    bubble_count = 1'b0;
    if (flush) begin
      do_bubble    = 1'b1;
      bubble_count = 1'b1;
    end else if (stall) begin
      do_hold = 1'b1;
    end else if (hazard_stall) begin
      do_bubble    = 1'b1;
      bubble_count = 1'b1;
    end else if (id_valid) begin
      do_load = 1'b1;
    end else begin
      do_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || do_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ALUOp    <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_ctrl     <= '0;
    end else if (do_load) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ALUOp    <= id_ALUOp;
      ex_funct3   <= id_funct3;
      ex_funct7   <= id_funct7;
      ex_ctrl     <= id_ctrl;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble_count && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (do_hold && (stall_cnt != '1))       stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized + directed bench for id_ex_reg against a cycle-level behavioural model.
module tb_id_ex_reg;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_ALUOp, id_funct3;
  logic [6:0] id_funct7, id_ctrl;
  logic ex_valid, hazard_stall;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_ALUOp, ex_funct3;
  logic [6:0] ex_funct7, ex_ctrl;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ALUOp(id_ALUOp),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ALUOp(ex_ALUOp),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, as a plain record of fields
  typedef struct {
    bit valid;
    logic [63:0] pc, a, b, imm;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] aluop, f3;
    logic [6:0] f7, ctrl;
  } ex_t;

  ex_t m;
  int  m_bub = 0;
  int  m_stl = 0;
  ex_t empty_ex = '{default: 0};

  function automatic bit model_hazard();
    return id_valid && m.valid && m.ctrl[5] && (m.rd != 0) && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic model_edge();
    bit hz = model_hazard();
    if (rst) begin
      m = empty_ex; m_bub = 0; m_stl = 0;
    end else if (flush) begin
      m = empty_ex; m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
    end else if (stall) begin
      m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
    end else if (hz) begin
      m = empty_ex; m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
    end else if (id_valid) begin
      m = '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
            id_ALUOp, id_funct3, id_funct7, id_ctrl};
    end else begin
      m = empty_ex;
    end
  endtask

  // Inputs are set at the falling edge; check, advance model, wait for next falling edge
  task automatic step();
    #1;
    chk("ex_valid", 64'(ex_valid), 64'(m.valid));
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rs1_data", ex_rs1_data, m.a);
    chk("ex_rs2_data", ex_rs2_data, m.b);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs1", 64'(ex_rs1), 64'(m.rs1));
    chk("ex_rs2", 64'(ex_rs2), 64'(m.rs2));
    chk("ex_rd", 64'(ex_rd), 64'(m.rd));
    chk("ex_ALUOp", 64'(ex_ALUOp), 64'(m.aluop));
    chk("ex_funct3", 64'(ex_funct3), 64'(m.f3));
    chk("ex_funct7", 64'(ex_funct7), 64'(m.f7));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
    chk("hazard_stall", 64'(hazard_stall), 64'(model_hazard()));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stl));
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_id();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_pc       = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm      = {$urandom, $urandom};
    id_rs1      = 5'($urandom_range(0, 7));
    id_rs2      = 5'($urandom_range(0, 7));
    id_rd       = 5'($urandom_range(0, 7));
    id_ALUOp    = 3'($urandom);
    id_funct3   = 3'($urandom);
    id_funct7   = 7'($urandom);
    id_ctrl     = 7'($urandom);
  endtask

  task automatic set_instr(input logic [6:0] ctrl, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    rand_id();
    id_valid = 1'b1; id_ctrl = ctrl; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  initial begin
    m = empty_ex;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_id();
    @(negedge clk);
    step();                                   // reset state
    rst = 1'b0;

    // 1: basic load
    set_instr(7'b1000000, 5'd5, 5'd1, 5'd2);
    id_ALUOp = 3'b000; id_funct3 = 3'd1; id_funct7 = 7'h20;
    step();
    id_valid = 1'b0; step();

    // 2: load-use on rs2, dependent held until the bubble clears
    set_instr(7'b0100000, 5'd7, 5'd1, 5'd2); step();
    set_instr(7'b1000000, 5'd9, 5'd3, 5'd7); step(); step(); step();

    // 3: rd=x0 load, and non-load producer: no hazard
    set_instr(7'b0100000, 5'd0, 5'd1, 5'd2); step();
    set_instr(7'b1000000, 5'd4, 5'd0, 5'd0); step();
    set_instr(7'b1000000, 5'd6, 5'd1, 5'd2); step();
    set_instr(7'b1000000, 5'd8, 5'd6, 5'd6); step();

    // 4: three stall cycles with changing ID, then resume
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_id(); step(); end
    stall = 1'b0; rand_id(); id_valid = 1'b1; step();

    // 5: flush+stall, then flush coinciding with a hazard
    flush = 1'b1; stall = 1'b1; step();
    flush = 1'b0; stall = 1'b0;
    set_instr(7'b0100000, 5'd3, 5'd1, 5'd2); step();
    flush = 1'b1; set_instr(7'b1000000, 5'd4, 5'd3, 5'd3); step();
    flush = 1'b0; step();

    // 6: saturation with 20 flushes, reset mid-hazard
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_id(); step(); end
    flush = 1'b0;
    set_instr(7'b0100000, 5'd2, 5'd1, 5'd1); step();
    set_instr(7'b1000000, 5'd5, 5'd2, 5'd1); rst = 1'b1; step();
    rst = 1'b0; step(); step();

    // Random stress
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      rand_id();
      step();
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0; step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the RV64 pipeline.
- Captures decoded operands and control from the decode stage, and presents ALUOp/funct3/funct7 to the ALU control block and operands to the execute stage one cycle later.
- Owns load-use hazard detection and bubble insertion. Honours external stall and flush.
- Keeps saturating bubble/stall performance counters.

Parameters:
XLEN, 64, datapath width (operands, immediate, PC)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
stall  input  1  global pipeline hold (memory wait); freezes register contents
flush  input  1  kill the instruction entering EX (taken branch/jump resolved)
id_valid  input  1  decode stage holds a real instruction
id_pc  input  XLEN  instruction PC
id_rs1_data  input  XLEN  rs1 operand
id_rs2_data  input  XLEN  rs2 operand
id_imm  input  XLEN  sign-extended immediate
id_rs1  input  5  rs1 index
id_rs2  input  5  rs2 index
id_rd  input  5  destination index
id_ALUOp  input  3  ALU operation class to ALU control
id_funct3  input  3  instruction funct3
id_funct7  input  7  instruction funct7
id_ctrl  input  7  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump}
ex_valid  output  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  output  5  registered copies
ex_ALUOp  output  3  registered copy, feeds ALU control
ex_funct3  output  3  registered copy, feeds ALU control
ex_funct7  output  7  registered copy, feeds ALU control
ex_ctrl  output  7  registered copy
hazard_stall  output  1  combinational; holds PC and IF/ID this cycle
bubble_cnt  output  CNT_W  bubbles inserted since reset
stall_cnt  output  CNT_W  cycles held by stall since reset

Behaviour:
- All state updates occur on the rising edge of clk. Latency is 1 cycle from id_* to ex_*.
- Reset: all ex_* = 0, ex_valid = 0, bubble_cnt = 0, stall_cnt = 0.
- A bubble means:
  - ex_valid = 0, ex_ctrl = 0, ex_ALUOp = 0, ex_funct3 = 0, ex_funct7 = 0, ex_rd = 0.
  - ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1 and ex_rs2 are zeroed.
  - An all-zero ALUOp/funct pattern decodes as ADD, which is harmless.
- hazard_stall = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Purely combinational from current state and id_* inputs.
  - It is not gated by stall.
- Per-cycle priority, highest first:
  1. rst: reset values.
  2. flush: load a bubble; bubble_cnt += 1. A flush during stall still bubbles and stall_cnt does not increment.
  3. stall: hold all ex_* unchanged; stall_cnt += 1.
  4. hazard_stall: load a bubble; bubble_cnt += 1. Upstream holds, so the dependent instruction re-presents next cycle.
  5. Otherwise: load all id_* fields, with ex_valid = id_valid.
- id_valid = 0 in the load case:
  - Captures a bubble. Control is forced to 0 regardless of id_ctrl.
  - bubble_cnt is not incremented.
- Hazard resolves in exactly one bubble:
  - After the bubble, ex_valid = 0, so hazard_stall deasserts.
  - The dependent instruction loads on the following edge.
- rd = x0 never raises a hazard.
- Counters saturate at all-ones and do not wrap.
- Reset mid-stall or mid-hazard returns to the reset state on the next edge; no residual hold.
- No X propagation: every ex_* bit is driven from reset or a defined case.

Test Plan:
1. Reset, then load id_valid=1, ALUOp=000, funct3=1, funct7=0x20, rd=5, RegWrite=1 -> next cycle ex_valid=1, ex_ALUOp=000, ex_funct3=1, ex_funct7=0x20, ex_rd=5; counters 0.
2. Load-use: EX holds MemRead=1, rd=7; ID presents rs2=7 -> hazard_stall=1 for exactly one cycle; next cycle ex_valid=0, ex_ctrl=0; following cycle the dependent instruction appears in EX; bubble_cnt=1.
3. Same as 2 but rd=0, or EX MemRead=0 -> hazard_stall stays 0; no bubble.
4. stall=1 for 3 cycles while ID changes every cycle -> ex_* frozen at the pre-stall value; stall_cnt=3; load resumes the cycle stall drops.
5. flush and stall both high for 1 cycle -> ex_valid=0, ex_ctrl=0; bubble_cnt += 1; stall_cnt unchanged. Then flush together with a hazard -> a single bubble, bubble_cnt += 1.
6. CNT_W=4: 20 consecutive flush cycles -> bubble_cnt saturates at 15. Assert rst mid-sequence -> all outputs 0 next edge.
